// File: rtl/fib_index_if.sv
// fib_index_if: start/ready/done_tick handshake bundle for the inverse
// Fibonacci block. The signal set matches the Fibonacci generator, so the
// two blocks can be cross-checked against each other.
//
// Handshake: the requester holds start high while ready is high. The request
// is accepted on the rising edge where both are high, and v is captured on
// that same edge. done_tick then pulses for exactly one cycle. idx and exact
// are valid from the done_tick cycle and hold until the next completion.
//
// Signals:
//   start     master -> slave   request, sampled only while ready
//   v         master -> slave   20-bit value to invert
//   ready     slave  -> master  block is idle and can accept a request
//   done_tick slave  -> master  one-cycle completion pulse
//   idx       slave  -> master  largest i with F(i) <= v (0..30)
//   exact     slave  -> master  F(idx) == v
interface fib_index_if;
    logic        start;
    logic [19:0] v;
    logic        ready;
    logic        done_tick;
    logic [4:0]  idx;
    logic        exact;

    modport master (
        output start,
        output v,
        input  ready,
        input  done_tick,
        input  idx,
        input  exact
    );

    modport slave (
        input  start,
        input  v,
        output ready,
        output done_tick,
        output idx,
        output exact
    );
endinterface

// File: rtl/fib_index.sv
// fib_index: inverse Fibonacci FSMD. It returns the largest index i with
// F(i) <= v, using F(0)=0 and F(1)=1. It also flags whether v is itself a
// Fibonacci number.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high; forces idle and clears all data
//   bus          fib_index_if slave (start, v, ready, done_tick, idx, exact)
//   state_dbg_o  current FSM state code (2'd0 idle, 2'd1 op, 2'd2 done)
//
// The block walks the Fibonacci sequence upward, one term per cycle, until
// the next term would exceed the captured value. A result of idx=k takes
// k cycles in op. The worst case is 30 cycles.
module fib_index (
    input  logic        clk,
    input  logic        reset,
    fib_index_if.slave  bus,
    output logic [1:0]  state_dbg_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP   = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [19:0] v_reg_q;
    logic [19:0] t0_q;
    logic [19:0] t1_q;
    logic [4:0]  n_q;
    logic [4:0]  idx_q;
    logic        exact_q;

    // The next term needs 21 bits. F(31) does not fit in 20 bits, and the
    // carry must make the compare fail rather than wrap to a small value.
    logic [20:0] sum_d;
    assign sum_d = {1'b0, t0_q} + {1'b0, t1_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            v_reg_q <= '0;
            t0_q    <= '0;
            t1_q    <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            exact_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        v_reg_q <= bus.v;
                        t0_q    <= 20'd0;
                        t1_q    <= 20'd1;
                        n_q     <= 5'd1;
                        state_q <= ST_OP;
                    end
                end
                ST_OP: begin
                    if (v_reg_q == 20'd0) begin
                        // F(0)=0 is the only term not reachable from the
                        // t1=F(1) starting point, so it is handled here.
                        idx_q   <= 5'd0;
                        exact_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (sum_d <= {1'b0, v_reg_q}) begin
                        t0_q <= t1_q;
                        t1_q <= sum_d[19:0];
                        n_q  <= n_q + 5'd1;
                    end else begin
                        idx_q   <= n_q;
                        exact_q <= (t1_q == v_reg_q);
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = (state_q == ST_IDLE);
    assign bus.done_tick = (state_q == ST_DONE);
    assign bus.idx       = idx_q;
    assign bus.exact     = exact_q;
    assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_fib_index.sv
module tb_fib_index;

    logic       clk;
    logic       reset;
    logic [1:0] state_dbg;

    fib_index_if bus ();

    fib_index dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .state_dbg_o (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: Fibonacci terms from the recurrence, then a plain search.
    int fib [0:31];

    function automatic void ref_model(input int val, output int e_idx, output int e_exact);
        e_idx   = 0;
        e_exact = 0;
        for (int i = 0; i <= 31; i++) begin
            if (fib[i] <= val) e_idx = i;
            if (fib[i] == val) e_exact = 1;
        end
    endfunction

    // Issues one request and waits (bounded) for done_tick. r_cyc is the
    // cycle number, counted from the accepting edge, in which done_tick was
    // seen. glitch_at > 0 pulses start with v=50 during that cycle of op.
    task automatic run(input logic [19:0] v_in, input int glitch_at,
                       output int r_idx, output int r_exact, output int r_cyc,
                       output int r_ready1);
        int cyc;
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.ready && w < 5) begin
            @(negedge clk);
            w++;
        end
        bus.v     = v_in;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc       = 1;
        r_ready1  = int'(bus.ready);
        while (!bus.done_tick && cyc < 40) begin
            bus.start = (cyc == glitch_at);
            if (cyc == glitch_at) bus.v = 20'd50;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start = 1'b0;
        r_cyc     = cyc;
        r_idx     = int'(bus.idx);
        r_exact   = int'(bus.exact);
    endtask

    typedef struct {
        logic [19:0] v;
        int          e_idx;
        int          e_exact;
        int          e_cyc;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int ri;
        int rx;
        int rc;
        int rr;
        int ei;
        int ex;
        int w;
        logic [19:0] rv;

        n_cmp     = 0;
        n_bad     = 0;
        bus.start = 1'b0;
        bus.v     = '0;
        fib[0]    = 0;
        fib[1]    = 1;
        for (int i = 2; i <= 31; i++) fib[i] = fib[i-1] + fib[i-2];

        vecs[0] = '{20'd0,       0,  1, 2};
        vecs[1] = '{20'd1,       2,  1, 3};
        vecs[2] = '{20'd100,     11, 0, 12};
        vecs[3] = '{20'd6765,    20, 1, 21};
        vecs[4] = '{20'd832040,  30, 1, 31};
        vecs[5] = '{20'hFFFFF,   30, 0, 31};
        vecs[6] = '{20'd2,       3,  1, 4};
        vecs[7] = '{20'd4,       4,  0, 5};

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", int'(bus.ready), 1);
        check("reset_done", int'(bus.done_tick), 0);
        check("reset_idx", int'(bus.idx), 0);
        check("reset_exact", int'(bus.exact), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run(vecs[i].v, 0, ri, rx, rc, rr);
            check($sformatf("vec%0d_idx", i), ri, vecs[i].e_idx);
            check($sformatf("vec%0d_exact", i), rx, vecs[i].e_exact);
            check($sformatf("vec%0d_cycle", i), rc, vecs[i].e_cyc);
            check($sformatf("vec%0d_ready1", i), rr, 0);
        end

        // done_tick lasts one cycle, then ready returns and the result holds.
        run(20'd0, 0, ri, rx, rc, rr);
        @(posedge clk);
        #1;
        check("v0_done_one_cycle", int'(bus.done_tick), 0);
        check("v0_ready_back", int'(bus.ready), 1);
        check("v0_idx_hold", int'(bus.idx), 0);
        check("v0_exact_hold", int'(bus.exact), 1);

        // A start pulse in the middle of op is ignored.
        run(20'd6765, 5, ri, rx, rc, rr);
        check("glitch_idx", ri, 20);
        check("glitch_exact", rx, 1);
        check("glitch_cycle", rc, 21);

        // Reset at cycle 10 of a run abandons it with no done_tick.
        @(negedge clk);
        bus.v     = 20'd6765;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_ready", int'(bus.ready), 1);
        check("rst_mid_idx", int'(bus.idx), 0);
        check("rst_mid_exact", int'(bus.exact), 0);
        @(negedge clk);
        reset = 1'b0;
        w     = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.done_tick) w++;
        end
        check("rst_mid_no_done", w, 0);
        run(20'd2, 0, ri, rx, rc, rr);
        check("after_rst_idx", ri, 3);
        check("after_rst_exact", rx, 1);
        check("after_rst_cycle", rc, 4);

        // Round trip over every generator output F(0)..F(30).
        for (int i = 0; i <= 30; i++) begin
            ref_model(fib[i], ei, ex);
            run(fib[i][19:0], 0, ri, rx, rc, rr);
            check($sformatf("rt%0d_idx", i), ri, (i == 1) ? 2 : i);
            check($sformatf("rt%0d_exact", i), rx, 1);
            check($sformatf("rt%0d_model", i), ri, ei);
        end

        // Random values against the reference model.
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 2))
                0:       rv = 20'($urandom_range(0, 200));
                1:       rv = 20'($urandom_range(800000, 1048575));
                default: rv = 20'($urandom);
            endcase
            ref_model(int'(rv), ei, ex);
            run(rv, 0, ri, rx, rc, rr);
            check($sformatf("rnd_idx v=%0d", rv), ri, ei);
            check($sformatf("rnd_exact v=%0d", rv), rx, ex);
            check($sformatf("rnd_cycle v=%0d", rv), rc, ((ei > 1) ? ei : 1) + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
